// File: rtl/apu_pkg.sv
// Shared constants and types for the APU pulse-channel sweep/frequency generator.
package apu_pkg;

  localparam int unsigned DEF_PERIOD_WIDTH = 11;
  localparam int unsigned DEF_SHIFT_WIDTH  = 3;
  localparam int unsigned DEF_RATE_WIDTH   = 3;
  localparam int unsigned DEF_MIN_PERIOD   = 8;

  typedef enum logic {
    SWEEP_ADD = 1'b0,
    SWEEP_SUB = 1'b1
  } sweep_mode_e;

  // Duty sequences, indexed by duty setting then by step counter bit.
  localparam logic [0:3][7:0] DUTY_ROM = {
    8'b01000000,
    8'b01100000,
    8'b01111000,
    8'b10011111
  };

endpackage

// File: rtl/apu_down_counter.sv
// Down counter that reloads on zero (or on demand) and flags expiry while enabled.
module apu_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iEnable,
  input  logic             iForce_reload,
  input  logic [WIDTH-1:0] iReload,
  output logic             oExpire
);

  logic [WIDTH-1:0] count;

  assign oExpire = iEnable & (count == '0);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      count <= '0;
    end else if (iEnable) begin
      if (oExpire | iForce_reload) count <= iReload;
      else                         count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/apu_sweep_freq_gen.sv
// Pulse-channel period register, sweep unit, period timer and square output.
// Optional duty sequencer enabled by defining APU_DUTY_SEQ_EN.
module apu_sweep_freq_gen
  import apu_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int unsigned SHIFT_WIDTH  = DEF_SHIFT_WIDTH,
  parameter int unsigned RATE_WIDTH   = DEF_RATE_WIDTH,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned NEGATE_ONES  = 0
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
`ifdef APU_DUTY_SEQ_EN
  input  logic [1:0]              iDuty,
`endif
  input  logic                    iSweep_clk,
  input  logic                    iSweep_enable,
  input  logic [RATE_WIDTH-1:0]   iSweep_refresh_rate,
  input  logic                    iSweep_mode,
  input  logic [SHIFT_WIDTH-1:0]  iSweep_shift,
  input  logic                    iSweep_write,
  input  logic                    iPeriod_load,
  input  logic [PERIOD_WIDTH-1:0] iPeriod,
  output logic [PERIOD_WIDTH-1:0] oPeriod,
  output logic                    oTick,
  output logic                    oSweep_Silence,
  output logic                    oData
);

  localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH:0]   NegAdj    = (PERIOD_WIDTH+1)'(NEGATE_ONES);

  sweep_mode_e             mode;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] delta;
  logic [PERIOD_WIDTH:0]   sum;
  logic [PERIOD_WIDTH:0]   diff;
  logic [PERIOD_WIDTH:0]   target;
  logic                    mute;
  logic                    reload;
  logic                    divExpire;
  logic                    timerExpire;
  logic                    doSweep;

  assign mode  = sweep_mode_e'(iSweep_mode);
  assign delta = period >> iSweep_shift;
  assign sum   = {1'b0, period} + {1'b0, delta};
  assign diff  = {1'b0, period} - {1'b0, delta} - NegAdj;

  // A borrow out of the subtraction lands in the extra MSB; clamp to zero.
  always_comb begin
    target = sum;
    if (mode == SWEEP_SUB) target = diff[PERIOD_WIDTH] ? '0 : diff;
  end

  assign mute    = (period < MinPeriod) | ((mode == SWEEP_ADD) & target[PERIOD_WIDTH]);
  assign doSweep = divExpire & iSweep_enable & (iSweep_shift != '0) & ~mute;

  // A register write on the strobe cycle must count as a pending reload.
  apu_down_counter #(.WIDTH(RATE_WIDTH)) uSweepDivider (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iEnable       (iSweep_clk),
    .iForce_reload (reload | iSweep_write),
    .iReload       (iSweep_refresh_rate),
    .oExpire       (divExpire)
  );

  apu_down_counter #(.WIDTH(PERIOD_WIDTH)) uTimer (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iEnable       (1'b1),
    .iForce_reload (1'b0),
    .iReload       (period),
    .oExpire       (timerExpire)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      period         <= '0;
      reload         <= 1'b0;
      oSweep_Silence <= 1'b1;
      oTick          <= 1'b0;
    end else begin
      if (iPeriod_load)  period <= iPeriod;
      else if (doSweep)  period <= target[PERIOD_WIDTH-1:0];
      if (iSweep_clk)        reload <= 1'b0;
      else if (iSweep_write) reload <= 1'b1;
      oSweep_Silence <= mute;
      oTick          <= timerExpire;
    end
  end

  assign oPeriod = period;

`ifdef APU_DUTY_SEQ_EN
  logic [2:0] step;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)        step <= '0;
    else if (timerExpire) step <= step - 3'd1;
  end

  assign oData = DUTY_ROM[iDuty][step];
`else
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)        oData <= 1'b0;
    else if (timerExpire) oData <= ~oData;
  end
`endif

endmodule
